// File: rtl/pow_pkg.sv
// Shared definitions for the square-and-multiply power unit: state encoding,
// the FSM state type and the default operand widths.
package pow_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int DEF_DW = 8;
    localparam int DEF_EW = 4;
    localparam int DEF_PW = 32;

    typedef enum logic [1:0] {
        ST_IDLE = IDLE,
        ST_CALC = CALC,
        ST_DONE = DONE
    } state_t;

endpackage

// File: rtl/pow_mul.sv
// Combinational unsigned W x W -> 2W multiplier used for both the P*B and B*B
// products of the square-and-multiply loop.
module pow_mul #(
    parameter int W = 32
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] y
);

    assign y = (2*W)'(a) * (2*W)'(b);

endmodule

// File: rtl/pow_sqmul.sv
// Fixed-latency unsigned power unit: o_P = i_X ** i_A via right-to-left
// square-and-multiply. Define POW_SQMUL_SAT_EN to saturate o_P on overflow.
module pow_sqmul
    import pow_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int EW = DEF_EW,
    parameter int PW = DEF_PW
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    input  logic [DW-1:0] i_X,
    input  logic [EW-1:0] i_A,
    output logic          o_busy,
    output logic          o_done,
    output logic [PW-1:0] o_P,
    output logic          o_ovf
);

    localparam int CW = $clog2(EW + 1);

    state_t          state, state_nxt;
    logic [PW-1:0]   b_q, p_q;
    logic [EW-1:0]   e_q;
    logic [CW-1:0]   cnt_q;
    logic            ovf_q, bov_q;
    logic [2*PW-1:0] pb_full, bb_full;
    logic            pb_hi, bb_hi, last_calc;

    pow_mul #(.W(PW)) u_mul_pb (.a(p_q), .b(b_q), .y(pb_full));
    pow_mul #(.W(PW)) u_mul_bb (.a(b_q), .b(b_q), .y(bb_full));

    assign pb_hi     = |pb_full[2*PW-1:PW];
    assign bb_hi     = |bb_full[2*PW-1:PW];
    // Loop length is tied to the exponent width, not its value, so latency is fixed.
    assign last_calc = (cnt_q == CW'(EW - 1));
    assign o_busy    = (state == ST_CALC) || (state == ST_DONE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (i_start)   state_nxt = ST_CALC;
            ST_CALC: if (last_calc) state_nxt = ST_DONE;
            ST_DONE:                state_nxt = ST_IDLE;
            default:                state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            b_q    <= '0;
            p_q    <= '0;
            e_q    <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            bov_q  <= 1'b0;
            o_P    <= '0;
            o_ovf  <= 1'b0;
            o_done <= 1'b0;
        end else begin
            o_done <= (state == ST_DONE);
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        b_q   <= PW'(i_X);
                        e_q   <= i_A;
                        p_q   <= PW'(1);
                        ovf_q <= 1'b0;
                        bov_q <= 1'b0;
                        cnt_q <= '0;
                    end
                end
                ST_CALC: begin
                    // A wrapped base only corrupts the result once it is multiplied in.
                    if (e_q[0]) begin
                        p_q <= pb_full[PW-1:0];
                        if (pb_hi || bov_q) ovf_q <= 1'b1;
                    end
                    b_q <= bb_full[PW-1:0];
                    if (bb_hi) bov_q <= 1'b1;
                    e_q   <= e_q >> 1;
                    cnt_q <= cnt_q + CW'(1);
                end
                ST_DONE: begin
`ifdef POW_SQMUL_SAT_EN
                    o_P <= ovf_q ? '1 : p_q;
`else
                    o_P <= p_q;
`endif
                    o_ovf <= ovf_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pow_sqmul.sv
// Self-checking bench for pow_sqmul (default widths), random and directed
// operands compared against a repeated-multiplication reference model.
module tb_pow_sqmul;

    localparam int DW  = 8;
    localparam int EW  = 4;
    localparam int PW  = 32;
    localparam int LAT = EW + 2;

    logic          clk, rst_n, start;
    logic [DW-1:0] x;
    logic [EW-1:0] a;
    logic          busy, done, ovf;
    logic [PW-1:0] p;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    pow_sqmul #(.DW(DW), .EW(EW), .PW(PW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_X(x), .i_A(a),
        .o_busy(busy), .o_done(done), .o_P(p), .o_ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: multiply x into an accumulator a times; overflow means the
    // exact power does not fit in PW bits.
    function automatic void model(input int unsigned xv, input int unsigned av,
                                  output logic [PW-1:0] pe, output logic oe);
        logic [63:0] acc;
        acc = 64'd1;
        oe  = 1'b0;
        for (int i = 0; i < int'(av); i++) begin
            acc = acc * 64'(xv);
            if (acc[63:PW] != 0) oe = 1'b1;
            acc = acc & 64'hFFFF_FFFF;
        end
`ifdef POW_SQMUL_SAT_EN
        pe = oe ? {PW{1'b1}} : acc[PW-1:0];
`else
        pe = acc[PW-1:0];
`endif
    endfunction

    // Called #1 after a rising edge; returns #1 after the sampling edge (edge 1).
    task automatic start_op(input int unsigned xv, input int unsigned av);
        x = DW'(xv);
        a = EW'(av);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Edge number (edge 1 = start sample) at which o_done is seen, -1 on timeout.
    task automatic wait_done(output int lat, output int dcyc);
        bit found = 0;
        lat = 1;
        dcyc = -1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            lat++;
            if (done) begin found = 1; dcyc = cyc; break; end
        end
        if (!found) lat = -1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; x = '0; a = '0;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        vectors++; if (p !== '0)      begin errors++; $display("FAIL reset_P: got %0d want 0", p); end
        vectors++; if (ovf !== 1'b0)  begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        int lat, dc;
        start_op(3, 4);
        vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", busy); end
        wait_done(lat, dc);
        vectors++; if (lat != LAT)   begin errors++; $display("FAIL basic_lat: got %0d want %0d", lat, LAT); end
        vectors++; if (p !== 32'd81) begin errors++; $display("FAIL basic_P: got %0d want 81", p); end
        vectors++; if (ovf !== 1'b0) begin errors++; $display("FAIL basic_ovf: got %b want 0", ovf); end
        @(posedge clk); #1;
        vectors++; if (done !== 1'b0) begin errors++; $display("FAIL basic_pulse: got %b want 0", done); end
        vectors++; if (p !== 32'd81)  begin errors++; $display("FAIL basic_hold: got %0d want 81", p); end
    endtask

    task automatic test_zero_exp;
        int lat, dc;
        int unsigned xs[3] = '{2, 0, 0};
        int unsigned as[3] = '{0, 0, 5};
        logic [PW-1:0] ps[3] = '{32'd1, 32'd1, 32'd0};
        for (int i = 0; i < 3; i++) begin
            start_op(xs[i], as[i]);
            wait_done(lat, dc);
            vectors++; if (lat != LAT)   begin errors++; $display("FAIL zero_lat%0d: got %0d want %0d", i, lat, LAT); end
            vectors++; if (p !== ps[i])  begin errors++; $display("FAIL zero_P%0d: got %0d want %0d", i, p, ps[i]); end
            vectors++; if (ovf !== 1'b0) begin errors++; $display("FAIL zero_ovf%0d: got %b want 0", i, ovf); end
        end
    endtask

    task automatic test_overflow;
        int lat, dc;
        logic [PW-1:0] pe;
        logic oe;
        model(255, 15, pe, oe);
        start_op(255, 15);
        wait_done(lat, dc);
        vectors++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", ovf); end
        vectors++; if (p !== pe)     begin errors++; $display("FAIL ovf_P: got %h want %h", p, pe); end
        vectors++; if (oe !== 1'b1)  begin errors++; $display("FAIL ovf_model: got %b want 1", oe); end
    endtask

    task automatic test_ignore_start;
        int ndone = 0;
        logic [PW-1:0] pcap = '0;
        start_op(2, 4);
        @(posedge clk); #1;
        x = 8'd5; a = 4'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (done) begin ndone++; pcap = p; end
        end
        vectors++; if (ndone != 1)      begin errors++; $display("FAIL ignore_count: got %0d want 1", ndone); end
        vectors++; if (pcap !== 32'd16) begin errors++; $display("FAIL ignore_P: got %0d want 16", pcap); end
    endtask

    task automatic test_reset_mid;
        int lat, dc;
        int ndone = 0;
        start_op(3, 4);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
        vectors++; if (p !== '0)      begin errors++; $display("FAIL abort_P: got %0d want 0", p); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        vectors++; if (ndone != 0) begin errors++; $display("FAIL abort_done: got %0d want 0", ndone); end
        start_op(7, 2);
        wait_done(lat, dc);
        vectors++; if (lat != LAT)   begin errors++; $display("FAIL abort_lat: got %0d want %0d", lat, LAT); end
        vectors++; if (p !== 32'd49) begin errors++; $display("FAIL abort_P: got %0d want 49", p); end
    endtask

    task automatic test_back_to_back;
        int lat, d1, d2;
        start_op(2, 3);
        wait_done(lat, d1);
        vectors++; if (p !== 32'd8) begin errors++; $display("FAIL b2b_P0: got %0d want 8", p); end
        start_op(3, 3);
        wait_done(lat, d2);
        vectors++; if (p !== 32'd27)  begin errors++; $display("FAIL b2b_P1: got %0d want 27", p); end
        vectors++; if (d2 - d1 != LAT) begin errors++; $display("FAIL b2b_gap: got %0d want %0d", d2 - d1, LAT); end
    endtask

    task automatic test_random;
        int lat, dc;
        int unsigned xv, av;
        logic [PW-1:0] pe;
        logic oe;
        for (int n = 0; n < 24; n++) begin
            xv = $urandom_range(0, 255);
            av = $urandom_range(0, 15);
            model(xv, av, pe, oe);
            start_op(xv, av);
            wait_done(lat, dc);
            vectors++; if (lat != LAT) begin errors++; $display("FAIL rnd_lat x=%0d a=%0d: got %0d want %0d", xv, av, lat, LAT); end
            vectors++; if (p !== pe)   begin errors++; $display("FAIL rnd_P x=%0d a=%0d: got %h want %h", xv, av, p, pe); end
            vectors++; if (ovf !== oe) begin errors++; $display("FAIL rnd_ovf x=%0d a=%0d: got %b want %b", xv, av, ovf, oe); end
            repeat ($urandom_range(1, 4)) @(posedge clk);
            #1;
            vectors++; if (p !== pe || ovf !== oe) begin errors++; $display("FAIL rnd_hold x=%0d a=%0d: got %h/%b want %h/%b", xv, av, p, ovf, pe, oe); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_exp();
        test_overflow();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/pow_sqmul.md
POW_SQMUL -- requirements
Module: pow_sqmul

Interface
REQ-001 SHALL have parameter DW, default 8, base operand width in bits (1..16).
REQ-002 SHALL have parameter EW, default 4, exponent operand width in bits (1..8).
REQ-003 SHALL have parameter PW, default 32, result width in bits (PW >= DW).
REQ-004 SHALL have port i_clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port i_rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port i_start  input  1  start request, sampled only in IDLE.
REQ-007 SHALL have port i_X  input  DW  base operand, unsigned.
REQ-008 SHALL have port i_A  input  EW  exponent operand, unsigned.
REQ-009 SHALL have port o_busy  output  1  high while an operation is in CALC or DONE.
REQ-010 SHALL have port o_done  output  1  one-cycle pulse marking a valid result.
REQ-011 SHALL have port o_P  output  PW  result, i_X**i_A; held until the next o_done.
REQ-012 SHALL have port o_ovf  output  1  overflow flag for the result on o_P; held with o_P.

Function
REQ-013 SHALL implement three states: IDLE, CALC, DONE.
REQ-014 SHALL, in IDLE with i_start=1, latch B<=zero-extended i_X, E<=i_A, P<=1, clear ovf and bov, clear cnt, and go to CALC.
REQ-015 SHALL, each CALC cycle, do: if E[0] then P<=low PW bits of P*B; B<=low PW bits of B*B; E<=E>>1; cnt<=cnt+1.
REQ-016 SHALL stay in CALC for exactly EW cycles regardless of operand values, then go to DONE.
REQ-017 SHALL, in DONE, drive o_P<=P, o_ovf<=ovf, o_done=1 for one cycle, then return to IDLE.
REQ-018 SHALL give fixed latency: o_done high on edge EW+2 counted from the edge sampling i_start (edge 1).
REQ-019 SHALL set bov when the full B*B product has nonzero bits above PW-1.
REQ-020 SHALL set ovf when E[0]=1 and either the full P*B product has nonzero bits above PW-1 or bov is already set.
REQ-021 SHALL ignore i_start while o_busy=1; no queueing.
REQ-022 SHALL give P=1 for i_A=0, including i_X=0, i.e. 0**0=1.
REQ-023 SHALL accept i_start in the cycle after DONE, giving back-to-back operations with a 1-cycle IDLE gap.
REQ-024 SHALL keep o_P and o_ovf stable between o_done pulses.

Reset
REQ-025 SHALL, with i_rst_n=0, immediately force state=IDLE, o_busy=0, o_done=0, o_P=0, o_ovf=0 and all internal registers to 0.
REQ-026 SHALL abort any operation in progress when reset is asserted mid-operation, with no o_done for the aborted operation.

Configuration
REQ-027 SHALL support macro POW_SQMUL_SAT_EN.
REQ-028 SHALL, with POW_SQMUL_SAT_EN defined, drive o_P to all-ones in DONE when ovf=1.
REQ-029 SHALL, without POW_SQMUL_SAT_EN, drive o_P to the result truncated modulo 2**PW; o_ovf is reported identically in both builds.

Structure
REQ-030 SHALL place the state encoding localparams (IDLE=2'd0, CALC=2'd1, DONE=2'd2) and default widths in shared package pow_pkg.
REQ-031 SHALL use one combinational sub-module, pow_mul (PW x PW -> 2PW unsigned), instantiated twice: P*B and B*B.

Verification
REQ-032 SHALL cover, with defaults: i_X=3, i_A=4, 1-cycle i_start -> o_done on edge 6, o_P=81, o_ovf=0.
REQ-033 SHALL cover: i_X=2, i_A=0 -> o_P=1; then i_X=0, i_A=0 -> o_P=1; and i_X=0, i_A=5 -> o_P=0; all o_ovf=0.
REQ-034 SHALL cover: i_X=255, i_A=15 -> o_ovf=1; o_P=32'hFFFFFFFF with POW_SQMUL_SAT_EN, else 255**15 mod 2**32.
REQ-035 SHALL cover: i_X=2, i_A=4, with i_start re-pulsed with i_X=5 on cycle 2 -> single o_done, o_P=16.
REQ-036 SHALL cover: i_rst_n low for 1 cycle during CALC -> o_busy=0, o_P=0, no o_done; next start with i_X=7, i_A=2 -> o_P=49.
REQ-037 SHALL cover: back-to-back starts with i_X=2, i_A=3 then i_X=3, i_A=3 -> o_P=8 then 27, o_done pulses 6 cycles apart.
